avg_filter_ctrl: RTL and testbench
==================================

# avg_filter_ctrl

Sequencer for the 8-bit AD moving-average path. It paces sampling with a programmable divider and clears the averaging filter at the start of each acquisition. It discards the filter's warm-up outputs, then delivers a burst (or continuous stream) of filtered samples to a downstream consumer over a valid/ready handshake, flagging overrun. It sits between the AD capture front end / averaging filter and the acquisition logic.

## Interface
- DIV_W, 16: width of sample-period divider.
- CNT_W, 16: width of burst counter.
- WARMUP, 17: strobes discarded after filter clear (window depth 16 + 1 output register stage).
- FILT_LAT, 1: cycles from `sample_en` to the corresponding valid `filt_data`.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins acquisition from IDLE.
- stop  in  1  one-cycle pulse; aborts acquisition.
- div  in  DIV_W  sample period minus 1, latched at start.
- burst_len  in  CNT_W  samples to deliver, latched at start; 0 = continuous.
- filt_data  in  8  filter output.
- sample_en  out  1  one-cycle strobe: ADC convert + filter advance.
- filt_clr_n  out  1  filter clear, active-low, one cycle.
- out_data  out  8  delivered filtered sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at final burst capture.
- overrun  out  1  sticky: unaccepted sample overwritten.

## Operation
- States: IDLE, CLEAR, FILL, RUN, DRAIN.
- IDLE: start && !stop -> CLEAR; latch div and burst_len; clear overrun. start && stop in the same cycle: stay IDLE.
- CLEAR: filt_clr_n=0 for exactly this cycle -> FILL.
- FILL/RUN: divider loads div on FILL entry, decrements each cycle, strobes sample_en at 0 and reloads. div=0 gives a strobe every cycle.
- FILL: counts strobes; after the WARMUP-th strobe -> RUN (the divider continues uninterrupted).
- RUN: every strobe is scheduled for capture FILT_LAT cycles later, tracked by a FILT_LAT-deep strobe delay line.
  - Non-zero burst_len: after the burst_len-th RUN strobe -> DRAIN, no further strobes.
- DRAIN: wait for outstanding captures; final capture -> IDLE with done=1 on that cycle.
- Capture: out_data <= filt_data, out_valid <= 1.
  - If out_valid && !out_ready at the capture cycle: the new data overwrites and overrun <= 1.
  - A capture in the same cycle as acceptance is not an overrun.
- out_valid clears on acceptance unless a capture occurs in the same cycle. It stays held across IDLE until accepted.
- stop in CLEAR/FILL/RUN/DRAIN: -> IDLE next cycle; no further strobes; pending captures dropped; out_valid/out_data untouched; no done.
- start while busy is ignored.
- Burst counter is CNT_W wide and counts RUN strobes. Continuous mode never enters DRAIN and does not wrap-terminate.

## Timing
- Reset values: sample_en=0, filt_clr_n=1, out_data=0, out_valid=0, busy=0, done=0, overrun=0, state IDLE.
- Cycle numbering: start sampled at edge 0; CLEAR during cycle 1; FILL entered at edge 2.
- First strobe at edge 2+div; strobes then every div+1 cycles.
- Strobe k (k≥1) at edge 2+div+(k-1)(div+1).
- RUN strobes are k = WARMUP+1 .. WARMUP+burst_len; each captures filt_data at edge (strobe edge + FILT_LAT).
- out_valid rises the cycle after the capture edge.
- All outputs registered; busy falls with done.

## Test plan
- Reset mid-RUN -> all outputs at reset values immediately (asynchronous); IDLE after release; no strobes.
- div=3, burst_len=2, filt_data=cycle counter, out_ready=1 -> filt_clr_n low at cycle 1; 19 strobes at edges 5,9,…,77; captures at edges 74 and 78; out_data=74 then 78; done at final capture; busy low after.
- div=0, burst_len=0, out_ready=1 -> strobe every cycle from edge 2; first capture at edge 20; continuous delivery until stop, then strobes cease next cycle and done stays 0.
- div=0, burst_len=3, out_ready=0 -> three captures, overrun=1 after second, out_data holds third; out_ready=1 then drops out_valid; next start clears overrun.
- start && stop in the same cycle in IDLE -> no state change. start during RUN -> ignored; strobe spacing unchanged.
- stop in DRAIN with one capture pending -> capture dropped, no done, out_valid unchanged.

Source files
------------

// File: rtl/avg_filter_ctrl.sv
// Acquisition sequencer for the 8-bit AD moving-average path: paces sampling,
// clears the filter, discards warm-up outputs and delivers a burst or stream.
`timescale 1ns/1ps
module avg_filter_ctrl #(
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 16,
  parameter int WARMUP   = 17,
  parameter int FILT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [7:0]       filt_data,
  output logic             sample_en,
  output logic             filt_clr_n,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [2:0]       fsm_state
);

  // out_valid/out_data form a valid/ready source: a beat transfers on a cycle
  // where out_valid && out_ready; a new capture replaces an unaccepted beat
  // and marks overrun.

  localparam int WU_W = $clog2(WARMUP + 1);
  localparam logic [FILT_LAT-1:0] TOP_MASK  = FILT_LAT'(1) << (FILT_LAT - 1);
  localparam logic [FILT_LAT-1:0] REST_MASK = ~TOP_MASK;

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, RUN, DRAIN} state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div_q, div_cnt;
  logic [CNT_W-1:0]    burst_q, burst_cnt;
  logic [WU_W-1:0]     warm_cnt;
  logic [FILT_LAT-1:0] line;
  logic                strobe, run_strobe, capture, last_capture;
  logic [7:0]          out_data_n;
  logic                out_valid_n, overrun_n;

  assign fsm_state    = state;
  assign strobe       = (state == FILL || state == RUN) && (div_cnt == '0) && !stop;
  assign run_strobe   = strobe && (state == RUN);
  // A capture in the same cycle as stop is dropped with the rest of the pipeline.
  assign capture      = line[FILT_LAT-1] && (state == RUN || state == DRAIN) && !stop;
  assign last_capture = capture && (state == DRAIN) && ((line & REST_MASK) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start && !stop) state_n = CLEAR;
      CLEAR: state_n = stop ? IDLE : FILL;
      FILL: begin
        if (stop) state_n = IDLE;
        else if (strobe && warm_cnt == WU_W'(WARMUP - 1)) state_n = RUN;
      end
      RUN: begin
        if (stop) state_n = IDLE;
        else if (run_strobe && burst_q != '0 && burst_cnt == burst_q - CNT_W'(1))
          state_n = DRAIN;
      end
      DRAIN: if (stop || last_capture) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_data_n  = out_data;
    out_valid_n = out_valid;
    overrun_n   = overrun;
    if (capture) begin
      out_data_n  = filt_data;
      out_valid_n = 1'b1;
      if (out_valid && !out_ready) overrun_n = 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end
    if (state == IDLE && start && !stop) overrun_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_en  <= 1'b0;
      filt_clr_n <= 1'b1;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sample_en  <= strobe;
      filt_clr_n <= (state_n != CLEAR);
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      busy       <= (state_n != IDLE);
      done       <= last_capture;
      overrun    <= overrun_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      burst_q   <= '0;
      div_cnt   <= '0;
      burst_cnt <= '0;
      warm_cnt  <= '0;
      line      <= '0;
    end else begin
      if (state == IDLE && start && !stop) begin
        div_q   <= div;
        burst_q <= burst_len;
      end
      // The divider free-runs through FILL into RUN so the strobe spacing never glitches.
      if (state == CLEAR) begin
        div_cnt   <= div_q;
        warm_cnt  <= '0;
        burst_cnt <= '0;
      end else if (state == FILL || state == RUN) begin
        div_cnt <= (div_cnt == '0) ? div_q : div_cnt - DIV_W'(1);
        if (strobe && state == FILL) warm_cnt <= warm_cnt + WU_W'(1);
        if (run_strobe) burst_cnt <= burst_cnt + CNT_W'(1);
      end
      line <= (state_n == IDLE) ? '0 : ((line << 1) | FILT_LAT'(run_strobe));
    end
  end

endmodule

// File: tb/tb_avg_filter_ctrl.sv
// Directed bench for avg_filter_ctrl: burst table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_avg_filter_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, stop, out_ready;
  logic [15:0] div, burst_len;
  logic [7:0]  filt_data;
  logic        sample_en, filt_clr_n, out_valid, busy, done, overrun;
  logic [7:0]  out_data;
  logic [2:0]  fsm_state;

  int cyc = 0;
  int base = 0;
  int tests = 0;
  int fails = 0;
  int strobe_q[$];
  int clr_q[$];
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int div; int burst; int n_strobe; int first_s; int last_s; int cap1; int done_e;
  } vec_t;
  vec_t vecs[4];

  avg_filter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .div(div),
    .burst_len(burst_len), .filt_data(filt_data), .sample_en(sample_en),
    .filt_clr_n(filt_clr_n), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  // clock / reset-free counters; filt_data equals the index of the edge sampling it
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign filt_data = 8'(cyc - base);

  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_en) strobe_q.push_back(cyc - base - 1);
      if (!filt_clr_n) clr_q.push_back(cyc - base - 1);
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic int rel();
    return cyc - base - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sample_en"}, int'(sample_en), 0);
    check({tag, "_filt_clr_n"}, int'(filt_clr_n), 1);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_state"}, int'(fsm_state), 0);
  endtask

  task automatic do_start(input int d, input int b);
    div = 16'(d);
    burst_len = 16'(b);
    start = 1'b1;
    base = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_to(input int e);
    for (int t = 0; t < 1000 && rel() < e; t++) step();
  endtask

  initial begin
    int s0, c0, d0, done_e, nstb, first_s, last_s;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    div = '0; burst_len = '0;
    vecs[0] = '{3, 2, 19, 5, 77, 74, 78};
    vecs[1] = '{0, 1, 18, 2, 19, 20, 20};
    vecs[2] = '{1, 3, 20, 3, 41, 38, 42};
    vecs[3] = '{2, 1, 18, 4, 55, 56, 56};
    step(); step();
    check_reset("rst_init");
    rst_n = 1'b1;
    step();

    // burst table, consumer always ready
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      s0 = strobe_q.size();
      c0 = clr_q.size();
      do_start(vecs[i].div, vecs[i].burst);
      done_e = -1;
      for (int t = 0; t < 600 && done_e < 0; t++) begin
        if (rel() == vecs[i].cap1 - 1) check($sformatf("v%0d_pre_cap_valid", i), int'(out_valid), 0);
        if (rel() == vecs[i].cap1) begin
          check($sformatf("v%0d_cap1_valid", i), int'(out_valid), 1);
          check($sformatf("v%0d_cap1_data", i), int'(out_data), vecs[i].cap1 % 256);
        end
        if (done) done_e = rel();
        else step();
      end
      nstb = strobe_q.size() - s0;
      first_s = (nstb > 0) ? strobe_q[s0] : -1;
      last_s = (nstb > 0) ? strobe_q[strobe_q.size() - 1] : -1;
      check($sformatf("v%0d_done_edge", i), done_e, vecs[i].done_e);
      check($sformatf("v%0d_strobes", i), nstb, vecs[i].n_strobe);
      check($sformatf("v%0d_first_strobe", i), first_s, vecs[i].first_s);
      check($sformatf("v%0d_last_strobe", i), last_s, vecs[i].last_s);
      check($sformatf("v%0d_clr_count", i), clr_q.size() - c0, 1);
      check($sformatf("v%0d_clr_edge", i), (clr_q.size() > c0) ? clr_q[c0] : -1, 0);
      check($sformatf("v%0d_final_data", i), int'(out_data), vecs[i].done_e % 256);
      check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
      step();
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_accepted", i), int'(out_valid), 0);
    end

    // continuous stream, start while busy ignored, then stop
    s0 = strobe_q.size();
    d0 = done_cnt;
    do_start(0, 0);
    for (int t = 0; t < 100 && rel() < 40; t++) begin
      if (rel() == 19) check("cont_pre_cap_valid", int'(out_valid), 0);
      if (rel() >= 20) begin
        exp_q.push_back(8'(rel()));
        check("cont_data", int'(out_data), int'(exp_q.pop_front()));
        check("cont_valid", int'(out_valid), 1);
      end
      start = (rel() == 29);
      step();
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("cont_stop_busy", int'(busy), 0);
    check("cont_stop_state", int'(fsm_state), 0);
    for (int t = 0; t < 10; t++) step();
    check("cont_strobes", strobe_q.size() - s0, 39);
    check("cont_last_strobe", (strobe_q.size() > s0) ? strobe_q[strobe_q.size() - 1] : -1, 40);
    check("cont_no_done", done_cnt - d0, 0);

    // overrun with a stalled consumer
    out_ready = 1'b0;
    do_start(0, 3);
    run_to(20);
    check("ovr_cap1_valid", int'(out_valid), 1);
    check("ovr_cap1_flag", int'(overrun), 0);
    check("ovr_cap1_data", int'(out_data), 20);
    step();
    check("ovr_cap2_flag", int'(overrun), 1);
    step();
    check("ovr_done", int'(done), 1);
    check("ovr_cap3_data", int'(out_data), 22);
    out_ready = 1'b1;
    step();
    check("ovr_accept_valid", int'(out_valid), 0);
    check("ovr_sticky", int'(overrun), 1);
    do_start(0, 0);
    check("ovr_cleared_by_start", int'(overrun), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ovr_abort_busy", int'(busy), 0);

    // start and stop together in IDLE
    s0 = strobe_q.size();
    c0 = clr_q.size();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", int'(busy), 0);
    check("ss_state", int'(fsm_state), 0);
    step(); step(); step();
    check("ss_no_strobe", strobe_q.size() - s0, 0);
    check("ss_no_clr", clr_q.size() - c0, 0);

    // stop in DRAIN with one capture outstanding
    out_ready = 1'b1;
    d0 = done_cnt;
    do_start(0, 2);
    run_to(20);
    check("drain_state", int'(fsm_state), 4);
    check("drain_valid", int'(out_valid), 1);
    check("drain_data", int'(out_data), 20);
    out_ready = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("drain_stop_busy", int'(busy), 0);
    check("drain_stop_valid", int'(out_valid), 1);
    check("drain_stop_data", int'(out_data), 20);
    check("drain_stop_done", done_cnt - d0, 0);
    out_ready = 1'b1;
    step();
    check("drain_accept", int'(out_valid), 0);

    // asynchronous reset in the middle of RUN
    do_start(0, 0);
    run_to(25);
    check("mid_run_state", int'(fsm_state), 3);
    check("mid_run_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_async");
    step(); step();
    rst_n = 1'b1;
    s0 = strobe_q.size();
    for (int t = 0; t < 5; t++) step();
    check("rst_release_strobes", strobe_q.size() - s0, 0);
    check("rst_release_state", int'(fsm_state), 0);
    check("rst_release_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
